mem_arb2: RTL and testbench

//  Two-requester arbiter/sequencer in front of the single-port synchronous mem
//  (cs/we/addr/wdata in, registered rdata out). Two masters share one mem

---
 rtl/mem_arb2.sv | 160 ++++++++++++++++
 tb/tb_mem_arb2.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb2.sv
// Two-master round-robin arbiter in front of a single-port synchronous memory.
// Accepted requests are registered onto the mem port; read data returns to the issuer.
module mem_arb2 #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_rst_n,
  input  logic                  i_w_en,

  input  logic                  i_w_req0_valid,
  output logic                  o_w_req0_ready,
  input  logic                  i_w_req0_we,
  input  logic [ADDR_WIDTH-1:0] i_w_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_w_req0_wdata,
  output logic                  o_w_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_w_rsp0_rdata,

  input  logic                  i_w_req1_valid,
  output logic                  o_w_req1_ready,
  input  logic                  i_w_req1_we,
  input  logic [ADDR_WIDTH-1:0] i_w_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_w_req1_wdata,
  output logic                  o_w_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_w_rsp1_rdata,

  output logic                  o_w_mem_cs,
  output logic                  o_w_mem_we,
  output logic [ADDR_WIDTH-1:0] o_w_mem_addr,
  output logic [DATA_WIDTH-1:0] o_w_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_w_mem_rdata,

  output logic                  o_w_busy
);

  typedef struct packed {
    logic vld;
    logic id;
    logic rd;
  } tag_t;

  logic grant0, grant1, accept;

  // ptr_q = 0 favours master 0, ptr_q = 1 favours master 1
  logic ptr_q, ptr_d;

  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_id_q, mem_id_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  tag_t tag_q [RD_LAT+1];
  tag_t tag_d [RD_LAT+1];

  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;
  logic                  busy;

  always_comb begin
    grant0 = i_w_en & i_w_req0_valid & (~i_w_req1_valid | ~ptr_q);
    grant1 = i_w_en & i_w_req1_valid & (~i_w_req0_valid |  ptr_q);
    accept = grant0 | grant1;
    // Favour whichever master was not granted on this accept
    ptr_d  = accept ? grant0 : ptr_q;
  end

  always_comb begin
    mem_cs_d    = accept;
    mem_we_d    = 1'b0;
    mem_id_d    = mem_id_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (grant1) begin
      mem_we_d    = i_w_req1_we;
      mem_id_d    = 1'b1;
      mem_addr_d  = i_w_req1_addr;
      mem_wdata_d = i_w_req1_wdata;
    end else if (grant0) begin
      mem_we_d    = i_w_req0_we;
      mem_id_d    = 1'b0;
      mem_addr_d  = i_w_req0_addr;
      mem_wdata_d = i_w_req0_wdata;
    end
  end

  // Stage 0 tracks the command the mem samples this edge; the last stage lines
  // up with the cycle in which the mem drives its read data.
  always_comb begin
    tag_d[0].vld = mem_cs_q;
    tag_d[0].id  = mem_id_q;
    tag_d[0].rd  = ~mem_we_q;
    for (int i = 1; i <= RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    rsp0_valid_d = tag_q[RD_LAT].vld & tag_q[RD_LAT].rd & ~tag_q[RD_LAT].id;
    rsp1_valid_d = tag_q[RD_LAT].vld & tag_q[RD_LAT].rd &  tag_q[RD_LAT].id;
    rsp0_rdata_d = rsp0_valid_d ? i_w_mem_rdata : rsp0_rdata_q;
    rsp1_rdata_d = rsp1_valid_d ? i_w_mem_rdata : rsp1_rdata_q;
  end

  // A read sitting on the mem port counts as in flight as well
  always_comb begin
    busy = mem_cs_q & ~mem_we_q;
    for (int i = 0; i <= RD_LAT; i++) begin
      busy = busy | (tag_q[i].vld & tag_q[i].rd);
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      ptr_q        <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_id_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_id_q     <= mem_id_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign o_w_req0_ready = grant0;
  assign o_w_req1_ready = grant1;
  assign o_w_rsp0_valid = rsp0_valid_q;
  assign o_w_rsp1_valid = rsp1_valid_q;
  assign o_w_rsp0_rdata = rsp0_rdata_q;
  assign o_w_rsp1_rdata = rsp1_rdata_q;
  assign o_w_mem_cs     = mem_cs_q;
  assign o_w_mem_we     = mem_we_q;
  assign o_w_mem_addr   = mem_addr_q;
  assign o_w_mem_wdata  = mem_wdata_q;
  assign o_w_busy       = busy;

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2: RD_LAT=1 instance (a) and RD_LAT=2 instance (b),
// each backed by a behavioural memory model.
module tb_mem_arb2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int both_rdy = 0;

  logic rst_n;

  // instance a signals (RD_LAT = 1)
  logic       en, v0, r0, we0, v1, r1, we1, rv0, rv1, cs, mwe, busy;
  logic [7:0] ad0, wd0, ad1, wd1, rd0, rd1, maddr, mwd, mrd;
  // instance b signals (RD_LAT = 2)
  logic       b_en, b_v0, b_r0, b_we0, b_v1, b_r1, b_we1, b_rv0, b_rv1, b_cs, b_mwe, b_busy;
  logic [7:0] b_ad0, b_wd0, b_ad1, b_wd1, b_rd0, b_rd1, b_maddr, b_mwd, b_mrd;

  mem_arb2 #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(1)) u_dut_a (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_en(en),
    .i_w_req0_valid(v0), .o_w_req0_ready(r0), .i_w_req0_we(we0),
    .i_w_req0_addr(ad0), .i_w_req0_wdata(wd0), .o_w_rsp0_valid(rv0), .o_w_rsp0_rdata(rd0),
    .i_w_req1_valid(v1), .o_w_req1_ready(r1), .i_w_req1_we(we1),
    .i_w_req1_addr(ad1), .i_w_req1_wdata(wd1), .o_w_rsp1_valid(rv1), .o_w_rsp1_rdata(rd1),
    .o_w_mem_cs(cs), .o_w_mem_we(mwe), .o_w_mem_addr(maddr), .o_w_mem_wdata(mwd),
    .i_w_mem_rdata(mrd), .o_w_busy(busy)
  );

  mem_arb2 #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(2)) u_dut_b (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_en(b_en),
    .i_w_req0_valid(b_v0), .o_w_req0_ready(b_r0), .i_w_req0_we(b_we0),
    .i_w_req0_addr(b_ad0), .i_w_req0_wdata(b_wd0), .o_w_rsp0_valid(b_rv0),
    .o_w_rsp0_rdata(b_rd0),
    .i_w_req1_valid(b_v1), .o_w_req1_ready(b_r1), .i_w_req1_we(b_we1),
    .i_w_req1_addr(b_ad1), .i_w_req1_wdata(b_wd1), .o_w_rsp1_valid(b_rv1),
    .o_w_rsp1_rdata(b_rd1),
    .o_w_mem_cs(b_cs), .o_w_mem_we(b_mwe), .o_w_mem_addr(b_maddr), .o_w_mem_wdata(b_mwd),
    .i_w_mem_rdata(b_mrd), .o_w_busy(b_busy)
  );

  // Memory models: sampled on the edge after issue, rdata RD_LAT edges later
  logic [7:0] mema [256];
  logic [7:0] memb [256];
  logic [7:0] pa0, pa1, pb0, pb1, pb2;
  initial begin
    for (int i = 0; i < 256; i++) begin
      mema[i] = ~i[7:0];
      memb[i] = ~i[7:0];
    end
  end
  always @(posedge clk) begin
    if (cs) begin
      if (mwe) mema[maddr] <= mwd;
      pa0 <= mema[maddr];
    end
    pa1 <= pa0;
    if (b_cs) begin
      if (b_mwe) memb[b_maddr] <= b_mwd;
      pb0 <= memb[b_maddr];
    end
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign mrd   = pa1;
  assign b_mrd = pb2;

  // Response logs: cycle index and data of every strobe
  int         a0_cyc[$], a1_cyc[$], b0_cyc[$], b1_cyc[$];
  logic [7:0] a0_dat[$], a1_dat[$], b0_dat[$], b1_dat[$];
  always @(negedge clk) begin
    if (rv0 === 1'b1)   begin a0_cyc.push_back(cyc); a0_dat.push_back(rd0);   end
    if (rv1 === 1'b1)   begin a1_cyc.push_back(cyc); a1_dat.push_back(rd1);   end
    if (b_rv0 === 1'b1) begin b0_cyc.push_back(cyc); b0_dat.push_back(b_rd0); end
    if (b_rv1 === 1'b1) begin b1_cyc.push_back(cyc); b1_dat.push_back(b_rd1); end
    if ((r0 && r1) || (b_r0 && b_r1)) both_rdy++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 0; v0 = 0; we0 = 0; ad0 = 0; wd0 = 0; v1 = 0; we1 = 0; ad1 = 0; wd1 = 0;
    b_en = 0; b_v0 = 0; b_we0 = 0; b_ad0 = 0; b_wd0 = 0;
    b_v1 = 0; b_we1 = 0; b_ad1 = 0; b_wd1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    a0_cyc.delete(); a1_cyc.delete(); b0_cyc.delete(); b1_cyc.delete();
    a0_dat.delete(); a1_dat.delete(); b0_dat.delete(); b1_dat.delete();
  endtask

  task automatic test_reset();
    do_reset();
    en = 1; v0 = 1; we0 = 1; ad0 = 8'h55; wd0 = 8'h66;
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cs, mwe, maddr, mwd} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_mem_port: got cs=%b we=%b addr=%h wdata=%h want all 0",
               cs, mwe, maddr, mwd);
    end
    n_checks++;
    if ({rv0, rv1, rd0, rd1, busy} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v0=%b v1=%b d0=%h d1=%h busy=%b want all 0",
               rv0, rv1, rd0, rd1, busy);
    end
  endtask

  task automatic test_write_read();
    int ca;
    do_reset();
    en = 1; v0 = 1; we0 = 1; ad0 = 8'h10; wd0 = 8'hAA;
    @(negedge clk);
    n_checks++;
    if ({r0, r1} !== 2'b10) begin
      n_fail++; $display("FAIL wr_ready: got r0=%b r1=%b want 1 0", r0, r1);
    end
    step();
    n_checks++;
    if ({cs, mwe, maddr, mwd} !== {1'b1, 1'b1, 8'h10, 8'hAA}) begin
      n_fail++;
      $display("FAIL wr_issue: got cs=%b we=%b addr=%h wd=%h want 1 1 10 aa", cs, mwe, maddr, mwd);
    end
    we0 = 0;
    @(negedge clk);
    ca = cyc;
    step();
    v0 = 0;
    n_checks++;
    if ({cs, mwe, busy} !== 3'b101) begin
      n_fail++; $display("FAIL rd_issue: got cs=%b we=%b busy=%b want 1 0 1", cs, mwe, busy);
    end
    repeat (6) step();
    n_checks++;
    if (a0_cyc.size() != 1 || a1_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL rd_rsp_count: got rsp0=%0d rsp1=%0d want 1 0", a0_cyc.size(), a1_cyc.size());
    end else begin
      n_checks++;
      if (a0_cyc[0] != ca + 4 || a0_dat[0] !== 8'hAA) begin
        n_fail++;
        $display("FAIL rd_rsp: got cyc=%0d data=%h want cyc=%0d data=aa", a0_cyc[0], a0_dat[0],
                 ca + 4);
      end
    end
    n_checks++;
    if (rv0 !== 1'b0 || rd0 !== 8'hAA) begin
      n_fail++; $display("FAIL rd_hold: got v=%b d=%h want 0 aa", rv0, rd0);
    end
  endtask

  task automatic test_round_robin();
    int c0;
    do_reset();
    en = 1; v0 = 1; v1 = 1; ad0 = 8'h01; ad1 = 8'h02;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) c0 = cyc;
      n_checks++;
      if (r0 !== (k % 2 == 0) || r1 !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL rr_grant%0d: got r0=%b r1=%b", k, r0, r1);
      end
      step();
    end
    v0 = 0; v1 = 0;
    repeat (8) step();
    n_checks++;
    if (a0_cyc.size() != 2 || a1_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL rr_count: got rsp0=%0d rsp1=%0d want 2 2", a0_cyc.size(), a1_cyc.size());
    end else begin
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (a0_cyc[j] != c0 + 4 + 2 * j || a0_dat[j] !== 8'hFE) begin
          n_fail++;
          $display("FAIL rr_rsp0_%0d: got cyc=%0d d=%h want cyc=%0d d=fe", j, a0_cyc[j],
                   a0_dat[j], c0 + 4 + 2 * j);
        end
        n_checks++;
        if (a1_cyc[j] != c0 + 5 + 2 * j || a1_dat[j] !== 8'hFD) begin
          n_fail++;
          $display("FAIL rr_rsp1_%0d: got cyc=%0d d=%h want cyc=%0d d=fd", j, a1_cyc[j],
                   a1_dat[j], c0 + 5 + 2 * j);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    do_reset();
    en = 1; v1 = 1; we1 = 1; ad1 = 8'h2A; wd1 = 8'hBB;
    @(negedge clk);
    n_checks++;
    if (r1 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_wr_ready: got %b want 1", r1);
    end
    step();
    v1 = 0; v0 = 1; we0 = 0; ad0 = 8'h2A;
    @(negedge clk);
    c = cyc;
    n_checks++;
    if (r0 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_rd_ready: got %b want 1", r0);
    end
    step();
    v0 = 0;
    repeat (6) step();
    n_checks++;
    if (a0_cyc.size() != 1) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 1", a0_cyc.size());
    end else if (a0_cyc[0] != c + 4 || a0_dat[0] !== 8'hBB) begin
      n_fail++;
      $display("FAIL b2b_rsp: got cyc=%0d d=%h want cyc=%0d d=bb", a0_cyc[0], a0_dat[0], c + 4);
    end
  endtask

  task automatic test_enable();
    int c;
    do_reset();
    en = 0; v0 = 1; v1 = 1; ad0 = 8'h03; ad1 = 8'h04;
    @(negedge clk);
    n_checks++;
    if ({r0, r1} !== 2'b00) begin
      n_fail++; $display("FAIL en0_ready: got r0=%b r1=%b want 0 0", r0, r1);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (cs !== 1'b0) begin
      n_fail++; $display("FAIL en0_cs: got %b want 0", cs);
    end
    c = cyc;
    en = 1;
    #1;
    n_checks++;
    if ({r0, r1} !== 2'b10) begin
      n_fail++; $display("FAIL en1_first: got r0=%b r1=%b want 1 0", r0, r1);
    end
    step();
    en = 0;
    #1;
    n_checks++;
    if ({r0, r1} !== 2'b00) begin
      n_fail++; $display("FAIL en_drop: got r0=%b r1=%b want 0 0", r0, r1);
    end
    v0 = 0; v1 = 0;
    repeat (6) step();
    n_checks++;
    if (a0_cyc.size() != 1 || a1_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL en_inflight_count: got %0d %0d want 1 0", a0_cyc.size(), a1_cyc.size());
    end else if (a0_cyc[0] != c + 4 || a0_dat[0] !== 8'hFC) begin
      n_fail++;
      $display("FAIL en_inflight: got cyc=%0d d=%h want cyc=%0d d=fc", a0_cyc[0], a0_dat[0], c + 4);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    en = 1; v0 = 1; we0 = 0; ad0 = 8'h05;
    @(negedge clk);
    step();
    v0 = 0;
    n_checks++;
    if ({cs, busy} !== 2'b11) begin
      n_fail++; $display("FAIL rst_pre: got cs=%b busy=%b want 1 1", cs, busy);
    end
    step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rv0, busy, cs, mwe} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_flush: got rv0=%b busy=%b cs=%b we=%b want 0", rv0, busy, cs, mwe);
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    n_checks++;
    if (a0_cyc.size() != 0 || a1_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL rst_drop: got rsp0=%0d rsp1=%0d want 0 0", a0_cyc.size(), a1_cyc.size());
    end
  endtask

  task automatic test_rdlat2();
    int c, c0;
    do_reset();
    b_en = 1; b_v0 = 1; b_we0 = 1; b_ad0 = 8'h30; b_wd0 = 8'h77;
    @(negedge clk);
    step();
    b_we0 = 0;
    @(negedge clk);
    c = cyc;
    n_checks++;
    if (b_r0 !== 1'b1) begin
      n_fail++; $display("FAIL l2_rd_ready: got %b want 1", b_r0);
    end
    step();
    b_v0 = 0;
    repeat (8) step();
    n_checks++;
    if (b0_cyc.size() != 1) begin
      n_fail++; $display("FAIL l2_count: got %0d want 1", b0_cyc.size());
    end else if (b0_cyc[0] != c + 5 || b0_dat[0] !== 8'h77) begin
      n_fail++;
      $display("FAIL l2_rsp: got cyc=%0d d=%h want cyc=%0d d=77", b0_cyc[0], b0_dat[0], c + 5);
    end
    b0_cyc.delete(); b0_dat.delete();
    // ptr favours m1 after the last m0 accept
    b_v0 = 1; b_v1 = 1; b_ad0 = 8'h01; b_ad1 = 8'h02;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) c0 = cyc;
      n_checks++;
      if (b_r1 !== (k % 2 == 0) || b_r0 !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL l2_grant%0d: got r0=%b r1=%b", k, b_r0, b_r1);
      end
      step();
    end
    b_v0 = 0; b_v1 = 0;
    repeat (10) step();
    n_checks++;
    if (b0_cyc.size() != 4 || b1_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL l2_stream_count: got %0d %0d want 4 4", b0_cyc.size(), b1_cyc.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (b1_cyc[j] != c0 + 5 + 2 * j || b1_dat[j] !== 8'hFD ||
            b0_cyc[j] != c0 + 6 + 2 * j || b0_dat[j] !== 8'hFE) begin
          n_fail++;
          $display("FAIL l2_stream%0d: got c1=%0d d1=%h c0=%0d d0=%h want %0d fd %0d fe", j,
                   b1_cyc[j], b1_dat[j], b0_cyc[j], b0_dat[j], c0 + 5 + 2 * j, c0 + 6 + 2 * j);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_enable();
    test_reset_inflight();
    test_rdlat2();
    n_checks++;
    if (both_rdy != 0) begin
      n_fail++; $display("FAIL one_ready: got %0d dual-ready cycles want 0", both_rdy);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
